// File: rtl/dmem_request_ctrl.sv
// Data-memory request controller: turns a decoded load/store into a held ren/wen
// request with byte enables, waits for d_ready (or times out) and returns extended load data.
module dmem_request_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_ready,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              d_ready,
    output logic              dmem_ren,
    output logic              dmem_wen,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              misalign,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic        req, aligned, accept, timeout_hit;
    logic [1:0]  off_q, size_q;
    logic        uns_q, rd_q;
    logic [15:0] cnt;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return ~off[0];
            2'd2:    return off == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic rd, input logic [1:0] size, input logic [1:0] off);
        if (rd) return 4'b1111;
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0]        s;
        logic signed [31:0] sx;
        s = rdata >> {off, 3'b000};
        case (size)
            2'd0: begin
                sx = 32'(signed'(s[7:0]));
                return uns ? {24'h0, s[7:0]} : sx;
            end
            2'd1: begin
                sx = 32'(signed'(s[15:0]));
                return uns ? {16'h0, s[15:0]} : sx;
            end
            default: return rdata;
        endcase
    endfunction

    assign req         = (req_rd | req_wr) & i_ready;
    assign aligned     = is_aligned(req_size, req_addr[1:0]);
    assign accept      = (state == IDLE) && req && aligned;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        misalign  = 1'b0;
        case (state)
            IDLE: begin
                misalign = req & ~aligned;
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (d_ready || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, completion/timeout handling and load extraction
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            dmem_ren   <= 1'b0;
            dmem_wen   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            ld_data    <= '0;
            bus_err    <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= 1'b0;
            cnt        <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dmem_ren   <= req_rd;
                        dmem_wen   <= ~req_rd;
                        dmem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        dmem_be    <= be_of(req_rd, req_size, req_addr[1:0]);
                        dmem_wdata <= wdata_of(req_size, req_wdata);
                        off_q      <= req_addr[1:0];
                        size_q     <= req_size;
                        uns_q      <= req_uns;
                        rd_q       <= req_rd;
                        cnt        <= '0;
                    end
                end
                ACCESS: begin
                    // d_ready takes priority over a timeout in the same cycle
                    if (d_ready) begin
                        dmem_ren <= 1'b0;
                        dmem_wen <= 1'b0;
                        if (rd_q) ld_data <= load_extend(dmem_rdata, size_q, off_q, uns_q);
                    end else if (timeout_hit) begin
                        dmem_ren <= 1'b0;
                        dmem_wen <= 1'b0;
                        ld_data  <= '0;
                        bus_err  <= 1'b1;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_request_ctrl.sv
// Bench for dmem_request_ctrl: directed cases plus random load/store traffic
// compared against a byte-lane arithmetic model of the memory request rules.
module tb_dmem_request_ctrl;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              i_ready, req_rd, req_wr, req_uns, d_ready;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata, dmem_rdata;
    logic              dmem_ren, dmem_wen, stall, misalign, bus_err;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata, ld_data;
    logic [3:0]        dmem_be;

    always #5 CLK = ~CLK;

    dmem_request_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .i_ready(i_ready), .req_rd(req_rd), .req_wr(req_wr),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .dmem_rdata(dmem_rdata), .d_ready(d_ready), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall(stall),
        .ld_data(ld_data), .misalign(misalign), .bus_err(bus_err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ld_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, lane arithmetic on integers
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
        return (a % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input bit rd, input logic [1:0] sz, input logic [31:0] a);
        int mask;
        if (rd) return 4'hF;
        mask = ((1 << nbytes(sz)) - 1) << (a % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] sz,
                                           input logic [31:0] a, input bit uns);
        longint v, lim;
        int n;
        n = nbytes(sz);
        if (n == 4) return rdata;
        lim = longint'(1) << (8 * n);
        v   = (longint'(rdata) >> (8 * (a % 4))) % lim;
        if (!uns && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    task automatic txn(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                       input int k);
        bit ok, timed;
        ok    = m_aligned(sz, a);
        timed = 1'b0;
        @(negedge CLK);
        i_ready = 1'b1; req_rd = rd; req_wr = wr; req_size = sz; req_uns = uns;
        req_addr = a; req_wdata = wd; d_ready = 1'b0;
        #1;
        chk("accept_misalign", 32'(misalign), 32'(!ok));
        chk("accept_stall", 32'(stall), 32'(ok));
        if (!ok) begin
            @(negedge CLK);
            req_rd = 1'b0; req_wr = 1'b0;
            #1;
            chk("mis_no_req", {30'b0, dmem_ren, dmem_wen}, 32'd0);
            chk("mis_stall", 32'(stall), 32'd0);
            return;
        end
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                req_addr = $urandom; req_wdata = $urandom; req_uns = !uns;
            end
            #1;
            chk("acc_ren", 32'(dmem_ren), 32'(rd));
            chk("acc_wen", 32'(dmem_wen), 32'(!rd));
            chk("acc_addr", dmem_addr, a - (a % 4));
            chk("acc_be", 32'(dmem_be), 32'(m_be(rd, sz, a)));
            if (!rd) chk("acc_wdata", dmem_wdata, m_wdata(sz, wd));
            chk("acc_stall", 32'(stall), 32'd1);
            chk("acc_misalign", 32'(misalign), 32'd0);
            chk("acc_ld_hold", ld_data, ld_exp);
            chk("acc_bus_err", 32'(bus_err), 32'd0);
            if (c == k) begin
                d_ready = 1'b1; dmem_rdata = rdata;
                break;
            end
            if (c == TIMEOUT) timed = 1'b1;
        end
        if (timed) ld_exp = 32'd0;
        else if (rd) ld_exp = m_load(rdata, sz, a, uns);
        @(negedge CLK);
        d_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        #1;
        chk("done_req", {30'b0, dmem_ren, dmem_wen}, 32'd0);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_bus_err", 32'(bus_err), 32'(timed));
        chk("done_ld_data", ld_data, ld_exp);
        @(negedge CLK);
        req_rd = 1'b0; req_wr = 1'b0; d_ready = 1'b0;
        #1;
        chk("idle_bus_err", 32'(bus_err), 32'd0);
        chk("idle_req", {30'b0, dmem_ren, dmem_wen}, 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_ld_data", ld_data, ld_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rd, wr, uns;
        logic [1:0]  sz;
        logic [31:0] a;
        int          k;

        nRST = 1'b0; i_ready = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_uns = 1'b0; req_addr = '0; req_wdata = '0; dmem_rdata = '0; d_ready = 1'b0;
        ld_exp = 32'd0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_req", {30'b0, dmem_ren, dmem_wen}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be_wdata", {28'b0, dmem_be} | dmem_wdata, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_flags", {29'b0, stall, misalign, bus_err}, 32'd0);
        nRST = 1'b1;

        txn(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80AABBCC, 2);
        chk("lb_const", ld_data, 32'hFFFFFF80);
        txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80AABBCC, 1);
        chk("lbu_const", ld_data, 32'h00000080);
        txn(0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 32'h0, 3);
        chk("sh_ld_unchanged", ld_data, 32'h00000080);
        txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 1);
        txn(0, 1, 2'd1, 0, 32'h3, 32'h5555, 32'h0, 1);
        txn(1, 0, 2'd3, 0, 32'h200, 32'h0, 32'h0, 1);
        txn(1, 1, 2'd1, 0, 32'h2A2, 32'h0, 32'h9876FEDC, 2);
        txn(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h13579BDF, TIMEOUT + 3);
        chk("timeout_ld_zero", ld_data, 32'd0);
        txn(1, 0, 2'd1, 0, 32'h46, 32'h0, 32'hC0DE8001, TIMEOUT);

        // request without fetch complete is not a request
        @(negedge CLK);
        i_ready = 1'b0; req_rd = 1'b1; req_size = 2'd2; req_addr = 32'h101;
        #1;
        chk("noiready_misalign", 32'(misalign), 32'd0);
        chk("noiready_stall", 32'(stall), 32'd0);
        @(negedge CLK);
        req_rd = 1'b0; i_ready = 1'b1;
        #1;
        chk("noiready_ren", 32'(dmem_ren), 32'd0);

        // reset in the middle of an access
        @(negedge CLK);
        req_rd = 1'b1; req_size = 2'd2; req_addr = 32'h300; d_ready = 1'b0;
        @(negedge CLK);
        #1;
        chk("mid_ren_before", 32'(dmem_ren), 32'd1);
        nRST = 1'b0; req_rd = 1'b0;
        @(negedge CLK);
        #1;
        chk("mid_rst_req", {30'b0, dmem_ren, dmem_wen}, 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
        nRST = 1'b1;
        ld_exp = 32'd0;
        txn(0, 1, 2'd0, 0, 32'h305, 32'hA5A5A55A, 32'h0, 1);

        for (int i = 0; i < 80; i++) begin
            rd  = 1'($urandom_range(0, 1));
            wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
            k   = $urandom_range(1, TIMEOUT + 2);
            txn(rd, wr, sz, uns, a, $urandom, $urandom, k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
